// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter and its input conditioning.
package ps2_host_tx_pkg;

   // Transfer sequencing states
   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_SEND,
      S_ACK,
      S_WAITIDLE,
      S_RELEASE
   } state_e;

   // Defaults for a 6 MHz clock enable
   localparam int unsigned INHIBIT_120US  = 720;
   localparam int unsigned TIMEOUT_15MS   = 90000;
   localparam int unsigned FILTER_SAMPLES = 4;

   // Frame shifted out after the start bit: {stop, parity, data[7:0]}
   localparam int unsigned FRAME_W = 10;
   typedef logic [FRAME_W-1:0] frame_t;

   // Odd parity: parity bit set when data has an even number of ones
   function automatic frame_t make_frame(input logic [7:0] b);
      return {1'b1, ~^b, b};
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, plus a
// debounce on the clock line producing a filtered level and falling-edge strobe.
// The strobe is registered on ce and is meant to be consumed on the next ce tick.
module ps2_filter
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned FILTER = FILTER_SAMPLES
) (
   input  logic clock,
   input  logic reset,
   input  logic ce,
   input  logic clk_i,
   input  logic dat_i,
   output logic clk_level_o,
   output logic clk_fall_o,
   output logic dat_sync_o
);

   localparam int unsigned FCNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [1:0]        clk_sync_q;
   logic [1:0]        dat_sync_q;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              level_q, level_d;
   logic              fall_q, fall_d;

   // Two-flop synchronisers, free-running on the system clock
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], clk_i};
         dat_sync_q <= {dat_sync_q[0], dat_i};
      end
   end

   // Debounce: adopt a new clock level after FILTER consecutive differing ce samples
   always_comb begin
      level_d = level_q;
      fcnt_d  = fcnt_q;
      fall_d  = 1'b0;
      if (clk_sync_q[1] == level_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FCNT_W'(FILTER - 1)) begin
         level_d = clk_sync_q[1];
         fcnt_d  = '0;
         fall_d  = ~clk_sync_q[1];
      end else begin
         fcnt_d = fcnt_q + FCNT_W'(1);
      end
   end

   // Filter state advances only on the clock enable
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b1;
         fcnt_q  <= '0;
         fall_q  <= 1'b0;
      end else if (ce) begin
         level_q <= level_d;
         fcnt_q  <= fcnt_d;
         fall_q  <= fall_d;
      end
   end

   assign clk_level_o = level_q;
   assign clk_fall_o  = fall_q;
   assign dat_sync_o  = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. ps2ClkOe/ps2DatOe drive the open-drain
// pads at the chip boundary (pad = Oe ? 0 : Z); the pad levels come back on
// ps2Clk/ps2Dat. The keyboard receiver must ignore the bus while busy is high.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT = INHIBIT_120US,
   parameter int unsigned TIMEOUT = TIMEOUT_15MS,
   parameter int unsigned FILTER  = FILTER_SAMPLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       ps2Clk,
   input  logic       ps2Dat,
   output logic       ps2ClkOe,
   output logic       ps2DatOe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   // One counter serves both the inhibit hold (counts up to INHIBIT) and the
   // inter-edge timeout (counts up to TIMEOUT-1)
   localparam int unsigned CNT_MAX = (TIMEOUT > INHIBIT) ? TIMEOUT : INHIBIT + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   frame_t           shift_q, shift_d;
   logic [3:0]       idx_q, idx_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             clk_level;
   logic             clk_fall;
   logic             dat_sync;
   logic             timeout_hit;

   ps2_filter #(
      .FILTER (FILTER)
   ) u_filter (
      .clock       (clock),
      .reset       (reset),
      .ce          (ce),
      .clk_i       (ps2Clk),
      .dat_i       (ps2Dat),
      .clk_level_o (clk_level),
      .clk_fall_o  (clk_fall),
      .dat_sync_o  (dat_sync)
   );

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state and output logic for the transfer sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      error_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            // A start coinciding with a visible done/error pulse is not taken
            if (start && !done_q && !error_q) begin
               shift_d  = make_frame(data);
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               cnt_d    = '0;
               idx_d    = '0;
               state_d  = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(INHIBIT - 1)) begin
               dat_oe_d = 1'b1;
            end
            if (cnt_q == CNT_W'(INHIBIT)) begin
               clk_oe_d = 1'b0;
               cnt_d    = '0;
               idx_d    = '0;
               state_d  = S_SEND;
            end
         end

         S_SEND, S_ACK, S_WAITIDLE: begin
            // Timeout is checked first so it wins over a simultaneous edge
            if (timeout_hit) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               busy_d   = 1'b0;
               error_d  = 1'b1;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = clk_fall ? '0 : cnt_q + CNT_W'(1);
               if (state_q == S_SEND) begin
                  if (clk_fall) begin
                     dat_oe_d = ~shift_q[0];
                     shift_d  = {1'b1, shift_q[FRAME_W-1:1]};
                     idx_d    = idx_q + 4'd1;
                     if (idx_q == 4'd9) begin
                        state_d = S_ACK;
                     end
                  end
               end else if (state_q == S_ACK) begin
                  if (clk_fall) begin
                     if (!dat_sync) begin
                        state_d = S_WAITIDLE;
                     end else begin
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b0;
                        busy_d   = 1'b0;
                        error_d  = 1'b1;
                        state_d  = S_RELEASE;
                     end
                  end
               end else begin
                  if (clk_level && dat_sync) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
         end

         S_RELEASE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end

         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // Sequencer registers advance only on the clock enable
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         idx_q    <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else if (ce) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         clk_oe_q <= clk_oe_d;
         dat_oe_q <= dat_oe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign ps2ClkOe = clk_oe_q;
   assign ps2DatOe = dat_oe_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by the LED mask byte.
- Drives the PS/2 clock and data lines open-drain through two output-enable signals.
- Sits beside the keyboard receiver on the same 2-wire ps2 bus, clocked by the 48 MHz system clock and advanced only on the 6 MHz enable (ce600p).
- The keyboard receiver must ignore the bus while busy is high.

Parameters:
INHIBIT, 720, ce ticks the clock line is held low for request-to-send (120 us at 6 MHz; must be ≥600).
TIMEOUT, 90000, ce ticks allowed between successive device clock falling edges before abort (15 ms at 6 MHz).
FILTER, 4, consecutive identical ce samples required before a filtered PS/2 clock level changes.

Ports:
clock    in   1  system clock, 48 MHz
reset    in   1  asynchronous, active-low
ce       in   1  6 MHz clock enable; all state advances only when ce=1
start    in   1  request to send data; sampled on ce while idle
data     in   8  byte to send; captured on accepted start
ps2Clk   in   1  PS/2 clock line as seen at the pad
ps2Dat   in   1  PS/2 data line as seen at the pad
ps2ClkOe out  1  1 = pull PS/2 clock low
ps2DatOe out  1  1 = pull PS/2 data low
busy     out  1  transfer in progress
done     out  1  one-ce-tick pulse: byte acknowledged by device
error    out  1  one-ce-tick pulse: timeout or missing ack

Behaviour:
- Reset (async, active-low): state IDLE; ps2ClkOe=0, ps2DatOe=0, busy=0, done=0, error=0; counters cleared; filter levels = 1.
- Input conditioning:
  - ps2Clk and ps2Dat each pass through a 2-flop synchroniser on clock.
  - The clock line is additionally filtered: the filtered level changes only after FILTER consecutive equal ce samples.
  - Falling edge = filtered clock goes 1→0, detected on a ce tick.
- Parity: odd, computed as ~^data at capture.
- Shift register: 10 bits {stop=1, parity, data[7:0]}, shifted LSB first.
- States:
  - IDLE: busy=0. When start=1 on a ce tick → capture data; busy=1; ps2ClkOe=1; clear counter; go to INHIBIT. start while busy is ignored (no queue).
  - INHIBIT: count ce ticks. At count == INHIBIT-1: ps2DatOe=1 (start bit 0). On the next ce tick: ps2ClkOe=0 (release clock), clear counter; go to SEND with bit index 0.
  - SEND: on each falling edge, drive the current shift bit (ps2DatOe = ~bit), shift, index+1.
    - Edges 1–8 put data[0..7]; edge 9 puts parity; edge 10 releases data (stop=1).
    - After edge 10 → ACK.
  - ACK: on the next falling edge (11th), sample filtered ps2Dat.
    - 0 → go to WAITIDLE.
    - 1 → error pulse; go to RELEASE.
  - WAITIDLE: wait until filtered clock=1 and synced data=1; then done pulse; go to IDLE.
  - RELEASE: both Oe=0, busy=0; return to IDLE on the next ce tick.
- Timeout:
  - The counter clears on every falling edge and on entry to SEND.
  - In SEND/ACK/WAITIDLE, reaching TIMEOUT-1 → both Oe=0, error pulse, go to IDLE.
  - Timeout takes precedence over a simultaneous falling edge.
- busy is high from the ce tick that accepts start until the tick that issues done or error, inclusive.
- done and error are never asserted together.
- start during the same tick as a done/error pulse is ignored; it is accepted on the next IDLE tick.
- Reset mid-transfer releases both lines immediately (async).
- Latency: start accepted → clock pulled low on the same ce tick (registered output, visible after that tick).

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, INHIBIT, SEND, ACK, WAITIDLE, RELEASE);
  - default constants INHIBIT_120US=720 and TIMEOUT_15MS=90000 at 6 MHz.
- One natural sub-module: ps2_filter (2-flop synchroniser plus FILTER-sample debounce, outputs level and falling-edge strobe). The keyboard receiver can reuse it.
- Counter width: 17 bits, sized by $clog2(TIMEOUT).
- The top level forms the pads as open-drain: pad = Oe ? 0 : Z.

Test Plan:
1. Send 0xED; the device model clocks at ~12.5 kHz and acks. Required:
   - clock held low for 720 ce ticks (±1);
   - data bits seen on rising edges = 1,0,1,1,0,1,1,1, parity=1, stop=1;
   - done pulses once; busy falls with done.
2. Send 0x01 and 0x00. Required: parity bit = 0 and 1 respectively; done each time.
3. Device model never generates clocks after request-to-send. Required: error pulse exactly 90000 ce ticks after clock release; both Oe=0; busy=0; done never asserted.
4. Device model leaves data high at the 11th falling edge. Required: error pulse; lines released; next start with 0x55 succeeds (parity 1).
5. Assert start again at mid-byte (bit index 4) with data=0xFF. Required: ignored; the byte on the wire remains the original.
6. Assert reset low at edge 6. Required: ps2ClkOe=ps2DatOe=0 immediately, busy=0; after reset release, a fresh 0xF4 transfer completes with done.
